// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmitter and receiver: the frame
//   state encoding, the legal parameter ranges and the parity helper.
//   No ports; import with "import uart_pkg::*;".

package uart_pkg;

  // Frame sequencing states. SYNC is a one-tick wait after an accept so
  // that the start bit always occupies a full baud period.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Legal framing parameter limits.
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 8;
  localparam int MIN_STOP_BITS = 1;
  localparam int MAX_STOP_BITS = 2;

  // Parity of a data word. Unused upper bits must be zero. With odd set,
  // the result makes the total count of ones (data + parity) odd.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx
//   Serialises parallel words onto an idle-high UART line: one start bit,
//   DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
//   Every bit lasts exactly one baud_tick period; back-to-back frames
//   follow each other with no idle gap when tx_valid is held.
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   baud_tick  one-clock strobe per bit period (shared with the receiver)
//   tx_data    word to send, captured on accept
//   tx_valid   upstream has a word; held with stable data until accepted
//   tx_ready   combinational; accept = tx_valid && tx_ready
//   tx         registered serial line output, idles high
//   tx_busy    high whenever a frame is in progress
//   tx_done    one-clock pulse when the final stop bit period ends

module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS=%0d outside %0d..%0d", DATA_BITS, MIN_DATA_BITS, MAX_DATA_BITS);
  end
  if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS=%0d must be %0d or %0d", STOP_BITS, MIN_STOP_BITS, MAX_STOP_BITS);
  end

  localparam int              BCW       = $clog2(DATA_BITS);
  localparam logic [BCW-1:0]  LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            PAR_EN    = (PARITY_EN != 0);
  localparam logic            ODD       = (PARITY_ODD != 0);

  uart_state_t              state;
  uart_state_t              next_state;
  logic [DATA_BITS-1:0]     shift;
  logic [BCW-1:0]           bit_cnt;
  logic                     stop_cnt;
  logic                     par;
  logic                     last_stop_tick;
  logic                     last_data;
  logic                     accept;
  logic [MAX_DATA_BITS-1:0] data_ext;

  // The closing tick of the final stop bit is also an accept window, which
  // is what lets a held tx_valid start the next frame with no idle gap.
  assign last_stop_tick = (state == ST_STOP) && baud_tick && (stop_cnt == STOP_LAST);
  assign last_data      = (bit_cnt == LAST_BIT);
  assign accept         = tx_valid && tx_ready;

  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_BITS-1:0]  = tx_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. Leaving IDLE needs no tick; everything else waits for one.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (accept) next_state = ST_SYNC;
      ST_SYNC:   if (baud_tick) next_state = ST_START;
      ST_START:  if (baud_tick) next_state = ST_DATA;
      ST_DATA:   if (baud_tick && last_data) next_state = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_tick) next_state = ST_STOP;
      ST_STOP:   if (last_stop_tick) next_state = tx_valid ? ST_START : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs derived directly from state.
  always_comb begin
    tx_ready = (state == ST_IDLE) || last_stop_tick;
    tx_busy  = (state != ST_IDLE);
  end

  // Datapath: the line value for each bit is registered on the tick that
  // opens that bit's period, so tx only ever changes on a baud tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        shift <= tx_data;
        par   <= parity_bit(data_ext, ODD);
      end
      if (baud_tick) begin
        unique case (state)
          ST_SYNC: tx <= 1'b0;
          ST_START: begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            if (last_data) begin
              if (PAR_EN) begin
                tx <= par;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
          ST_STOP: begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              // A word accepted here goes straight to its start bit.
              if (tx_valid) tx <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Self-checking bench for uart_tx. Four instances cover 8N1, 8E1, 8O1
//   and 8N2 framing. Line samples are taken just after every baud tick
//   edge and packed LSB-first (sample 0 = start bit) for comparison with
//   hand-derived frame images.

module tb_uart_tx;

  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data_a  [NDUT];
  logic       tx_valid_a [NDUT];
  logic       tx_ready_a [NDUT];
  logic       tx_a       [NDUT];
  logic       tx_busy_a  [NDUT];
  logic       tx_done_a  [NDUT];

  int passed = 0;
  int total  = 0;
  int tick_div = 0;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [31:0] exp_bits;
    int          exp_len;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] exp_q [$];
  int         rx_frames;
  int         lb_dones;

  always #5 clk = ~clk;

  // Baud tick every fourth clock, updated away from the sampling points.
  always @(posedge clk) begin
    #2;
    tick_div  = (tick_div + 1) % 4;
    baud_tick = (tick_div == 0);
  end

  uart_tx u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]), .tx_ready(tx_ready_a[0]),
    .tx(tx_a[0]), .tx_busy(tx_busy_a[0]), .tx_done(tx_done_a[0])
  );

  uart_tx #(.PARITY_EN(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]), .tx_ready(tx_ready_a[1]),
    .tx(tx_a[1]), .tx_busy(tx_busy_a[1]), .tx_done(tx_done_a[1])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]), .tx_ready(tx_ready_a[2]),
    .tx(tx_a[2]), .tx_busy(tx_busy_a[2]), .tx_done(tx_done_a[2])
  );

  uart_tx #(.STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tx_data_a[3]), .tx_valid(tx_valid_a[3]), .tx_ready(tx_ready_a[3]),
    .tx(tx_a[3]), .tx_busy(tx_busy_a[3]), .tx_done(tx_done_a[3])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic reportTimeout(input string name);
    total++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Sends one word and captures the line at every tick until tx_done.
  task automatic applyStimulus(input int d, input logic [7:0] data,
                               output logic [31:0] bits, output int nbits,
                               output int dones, output int busy_lows,
                               output logic idle_ok);
    bit got;
    got = 0;
    bits = '0; nbits = 0; dones = 0; busy_lows = 0; idle_ok = 0;
    @(negedge clk);
    tx_data_a[d]  = data;
    tx_valid_a[d] = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (tx_ready_a[d]) begin got = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tx_valid_a[d] = 1'b0;
    if (!got) begin reportTimeout("accept"); return; end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (tx_done_a[d]) begin dones++; break; end
      if (!tx_busy_a[d]) busy_lows++;
      if (baud_tick && nbits < 32) begin bits[nbits] = tx_a[d]; nbits++; end
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (tx_done_a[d]) dones++;
    end
    idle_ok = tx_a[d] && !tx_busy_a[d] && tx_ready_a[d];
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] bits;
    int          nbits, dones, busy_lows, ready_pulses, tx_lows;
    logic        idle_ok;
    bit          got;

    for (int d = 0; d < NDUT; d++) begin
      tx_data_a[d]  = 8'h00;
      tx_valid_a[d] = 1'b0;
    end

    vecs[0] = '{0, 8'hA5, 32'h0000034A, 10};
    vecs[1] = '{0, 8'h00, 32'h00000200, 10};
    vecs[2] = '{0, 8'hFF, 32'h000003FE, 10};
    vecs[3] = '{0, 8'h3C, 32'h00000278, 10};
    vecs[4] = '{1, 8'hA5, 32'h0000054A, 11};
    vecs[5] = '{1, 8'h01, 32'h00000602, 11};
    vecs[6] = '{2, 8'hA5, 32'h0000074A, 11};
    vecs[7] = '{2, 8'h01, 32'h00000402, 11};
    vecs[8] = '{3, 8'h00, 32'h00000600, 11};
    vecs[9] = '{3, 8'h5A, 32'h000006B4, 11};

    // Reset state: {tx, busy, done, ready} = 1,0,0,1 once reset releases.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++)
      checkOutput($sformatf("reset state dut%0d", d),
                  {28'd0, tx_a[d], tx_busy_a[d], tx_done_a[d], tx_ready_a[d]}, 32'h9);

    // Table-driven single frames.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].dut, vecs[i].data, bits, nbits, dones, busy_lows, idle_ok);
      checkOutput($sformatf("vec%0d line bits", i), bits, vecs[i].exp_bits);
      checkOutput($sformatf("vec%0d frame length", i), nbits, vecs[i].exp_len);
      checkOutput($sformatf("vec%0d done pulses", i), dones, 1);
      checkOutput($sformatf("vec%0d busy gaps", i), busy_lows, 0);
      checkOutput($sformatf("vec%0d idle after", i), {31'd0, idle_ok}, 1);
    end

    // Back-to-back: 0x55 then 0xAA with tx_valid held throughout.
    bits = '0; nbits = 0; dones = 0; ready_pulses = 0; got = 0;
    @(negedge clk);
    tx_data_a[0]  = 8'h55;
    tx_valid_a[0] = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (tx_ready_a[0]) begin got = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tx_data_a[0] = 8'hAA;
    if (!got) reportTimeout("b2b first accept");
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      got = tx_valid_a[0] && tx_ready_a[0];
      if (got) ready_pulses++;
      @(posedge clk); #1;
      if (got) tx_valid_a[0] = 1'b0;
      if (tx_done_a[0]) begin
        dones++;
        if (dones == 2) break;
      end
      if (baud_tick && nbits < 32) begin bits[nbits] = tx_a[0]; nbits++; end
    end
    tx_valid_a[0] = 1'b0;
    checkOutput("b2b line bits", bits, 32'h000D52AA);
    checkOutput("b2b length", nbits, 20);
    checkOutput("b2b done pulses", dones, 2);
    checkOutput("b2b ready pulses", ready_pulses, 1);

    // Reset during data bit 3 of 0xFF.
    repeat (8) @(posedge clk);
    @(negedge clk);
    tx_data_a[0]  = 8'hFF;
    tx_valid_a[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 64; c++) begin
      if (tx_ready_a[0]) begin got = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tx_valid_a[0] = 1'b0;
    if (!got) reportTimeout("rst-test accept");
    nbits = 0;
    for (int c = 0; c < 100 && nbits < 5; c++) begin
      @(posedge clk); #1;
      if (baud_tick) nbits++;
    end
    checkOutput("rst-test busy before reset", {31'd0, tx_busy_a[0]}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst-test state after reset",
                {28'd0, tx_a[0], tx_busy_a[0], tx_done_a[0], tx_ready_a[0]}, 32'h9);
    @(negedge clk);
    rst = 1'b0;
    dones = 0; tx_lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (tx_done_a[0]) dones++;
      if (!tx_a[0]) tx_lows++;
    end
    checkOutput("rst-test no done", dones, 0);
    checkOutput("rst-test line idle", tx_lows, 0);
    applyStimulus(0, 8'h3C, bits, nbits, dones, busy_lows, idle_ok);
    checkOutput("rst-test next frame bits", bits, 32'h00000278);
    checkOutput("rst-test next frame done", dones, 1);

    // Loopback: 256 random words streamed through a line decoder.
    rx_frames = 0;
    lb_dones  = 0;
    fork
      begin : driver
        bit ok;
        @(negedge clk);
        tx_data_a[0]  = 8'($urandom_range(0, 255));
        tx_valid_a[0] = 1'b1;
        for (int i = 0; i < 256; i++) begin
          ok = 0;
          for (int c = 0; c < 200; c++) begin
            if (tx_ready_a[0]) begin ok = 1; break; end
            @(negedge clk);
          end
          if (!ok) begin reportTimeout("loopback driver"); break; end
          @(posedge clk);
          exp_q.push_back(tx_data_a[0]);
          #1;
          if (i < 255) tx_data_a[0] = 8'($urandom_range(0, 255));
          else         tx_valid_a[0] = 1'b0;
          @(negedge clk);
        end
        tx_valid_a[0] = 1'b0;
      end
      begin : monitor
        bit         in_frame;
        int         cnt;
        logic [7:0] sh;
        logic [7:0] e;
        in_frame = 0; cnt = 0; sh = '0;
        for (int c = 0; c < 30000; c++) begin
          @(posedge clk); #1;
          if (tx_done_a[0]) lb_dones++;
          if (baud_tick) begin
            if (!in_frame) begin
              if (!tx_a[0]) begin in_frame = 1; cnt = 0; sh = '0; end
            end else if (cnt < 8) begin
              sh[cnt] = tx_a[0];
              cnt++;
            end else begin
              in_frame = 0;
              rx_frames++;
              if (exp_q.size() == 0) begin
                total++;
                $display("[TB] FAIL loopback frame %0d: got 0x%0h, expected nothing queued", rx_frames, sh);
              end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("loopback frame %0d", rx_frames), {23'd0, tx_a[0], sh}, {23'd0, 1'b1, e});
              end
            end
          end
          if (rx_frames >= 256 && lb_dones >= 256) break;
        end
      end
    join
    checkOutput("loopback frames", rx_frames, 256);
    checkOutput("loopback done pulses", lb_dones, 256);
    checkOutput("loopback queue drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
